// File: rtl/i2c_init_sequencer.sv
// Walks an external register table and drives a register-write engine
// one entry at a time, with per-entry retries, a watchdog and a fixed inter-write gap.
module i2c_init_sequencer #(
  parameter int unsigned NUM_REGS        = 16,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned GAP_CYCLES      = 1000,
  parameter int unsigned WATCHDOG_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output logic [7:0] tbl_addr,
  input  logic [6:0] tbl_dev_addr,
  input  logic [7:0] tbl_reg_addr,
  input  logic [7:0] tbl_data,
  output logic [6:0] wr_dev_address,
  output logic [7:0] wr_reg_address,
  output logic [7:0] wr_data,
  output logic       wr_start,
  input  logic       wr_done,
  input  logic       wr_failure,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [7:0] error_index
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned RT_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int unsigned WD_W  = (WATCHDOG_CYCLES < 2) ? 1 : $clog2(WATCHDOG_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRIES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RT_W-1:0]  rt_q, rt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [6:0]       wr_dev_q, wr_dev_d;
  logic [7:0]       wr_reg_q, wr_reg_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             wr_start_q, wr_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       err_idx_q, err_idx_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rt_q       <= '0;
      gap_q      <= '0;
      wd_q       <= '0;
      wr_dev_q   <= '0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      wr_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rt_q       <= rt_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      wr_dev_q   <= wr_dev_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      wr_start_q <= wr_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rt_d       = rt_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    wr_dev_d   = wr_dev_q;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    wr_start_d = 1'b0;
    err_idx_d  = err_idx_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          idx_d   = '0;
          rt_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        wr_dev_d  = tbl_dev_addr;
        wr_reg_d  = tbl_reg_addr;
        wr_data_d = tbl_data;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        wr_start_d = 1'b1;
        wd_d       = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Failure (engine or watchdog) outranks a coincident done
        if (wr_failure || (wd_q == WD_LAST)) begin
          if (rt_q < RT_MAX) begin
            rt_d    = RT_W'(rt_q + 1'b1);
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            err_idx_d = idx_q;
            state_d   = S_ERROR;
          end
        end else if (wr_done) begin
          rt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = IDX_W'(idx_q + 1'b1);
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else begin
          wd_d = WD_W'(wd_q + 1'b1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_FETCH;
        else                   gap_d   = GAP_W'(gap_q + 1'b1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  assign tbl_addr       = idx_q;
  assign wr_dev_address = wr_dev_q;
  assign wr_reg_address = wr_reg_q;
  assign wr_data        = wr_data_q;
  assign wr_start       = wr_start_q;
  assign busy           = busy_q;
  assign init_done      = done_q;
  assign init_error     = err_q;
  assign error_index    = err_idx_q;

endmodule
